// File: rtl/uart_rx_cfg_if.sv
// Read-side bundle of uart_rx_cfg: holding-register data, ready/valid handshake
// and the per-word status flags that travel with it.
interface uart_rx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] uart_rd_data;
    logic                 uart_rd_valid;
    logic                 uart_rd_ready;
    logic                 rx_parity_err;
    logic                 rx_frame_err;
    logic                 rx_break;
    logic                 rx_overrun;

    modport master (
        output uart_rd_data, uart_rd_valid, rx_parity_err, rx_frame_err, rx_break, rx_overrun,
        input  uart_rd_ready
    );

    modport slave (
        input  uart_rd_data, uart_rd_valid, rx_parity_err, rx_frame_err, rx_break, rx_overrun,
        output uart_rd_ready
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: majority-vote oversampling, parity/stop checking,
// break detection and a single-entry holding register with overrun reporting.
module uart_rx_cfg #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          uart_rxd_i,
    output logic          rx_busy_o,
    uart_rx_cfg_if.master rd_if
);
    localparam int DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SMP_W = $clog2(OVERSAMPLE);

    if (DIV < 1 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_cfg
        $fatal(1, "uart_rx_cfg: illegal parameter combination");
    end

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [SMP_W-1:0] SMP_LAST  = SMP_W'(OVERSAMPLE - 1);
    localparam logic [SMP_W-1:0] SMP_A     = SMP_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SMP_W-1:0] SMP_B     = SMP_W'(OVERSAMPLE / 2);
    localparam logic [SMP_W-1:0] SMP_C     = SMP_W'(OVERSAMPLE / 2 + 1);
    localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic             ODD       = (PARITY == 2);

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_WAIT_HIGH
    } state_e;

    state_e               state_q, state_d;
    logic [1:0]           sync_q;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [SMP_W-1:0]     smp_q, smp_d;
    logic [3:0]           bit_q, bit_d;
    logic [1:0]           samp_q, samp_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_err_q, par_err_d;
    logic                 stop_low_q, stop_low_d;
    logic                 line_hi_q, line_hi_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 pe_q, pe_d, fe_q, fe_d, brk_q, brk_d;
    logic                 ovr_q, ovr_d;
    logic                 busy_q;

    logic rxs, tick, decide, maj, commit;

    assign rxs    = sync_q[1];
    assign tick   = (div_q == DIV_LAST);
    assign decide = tick && (smp_q == SMP_C);
    assign maj    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs) | (samp_q[1] & rxs);

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        div_d      = tick ? '0 : div_q + 1'b1;
        smp_d      = smp_q;
        bit_d      = bit_q;
        samp_d     = samp_q;
        shift_d    = shift_q;
        par_err_d  = par_err_q;
        stop_low_d = stop_low_q;
        line_hi_d  = line_hi_q;
        commit     = 1'b0;

        if (tick) begin
            smp_d = (smp_q == SMP_LAST) ? '0 : smp_q + 1'b1;
            if (smp_q == SMP_A) samp_d[0] = rxs;
            if (smp_q == SMP_B) samp_d[1] = rxs;
        end

        unique case (state_q)
            ST_IDLE: begin
                smp_d = '0;
                bit_d = '0;
                if (!rxs) begin
                    // Realign the tick phase to the falling edge of the start bit.
                    state_d    = ST_START;
                    div_d      = '0;
                    par_err_d  = 1'b0;
                    stop_low_d = 1'b0;
                    line_hi_d  = 1'b0;
                end
            end
            ST_START: begin
                if (decide) state_d = maj ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (decide) begin
                    shift_d   = {maj, shift_q[DATA_BITS-1:1]};
                    line_hi_d = line_hi_q | maj;
                    if (bit_q == LAST_DATA) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (decide) begin
                    par_err_d = maj ^ (^shift_q) ^ ODD;
                    line_hi_d = line_hi_q | maj;
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (decide) begin
                    stop_low_d = stop_low_q | ~maj;
                    line_hi_d  = line_hi_q | maj;
                    if (bit_q == LAST_STOP) begin
                        commit  = 1'b1;
                        bit_d   = '0;
                        state_d = rxs ? ST_IDLE : ST_WAIT_HIGH;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                if (rxs) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Holding register: a commit may reuse the slot in the cycle it is being read out.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        pe_d    = pe_q;
        fe_d    = fe_q;
        brk_d   = brk_q;
        ovr_d   = 1'b0;
        if (valid_q && rd_if.uart_rd_ready) valid_d = 1'b0;
        if (commit) begin
            if (!valid_q || rd_if.uart_rd_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
                pe_d    = par_err_q;
                fe_d    = stop_low_q | ~maj;
                brk_d   = ~(line_hi_q | maj);
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q     <= 2'b11;
            state_q    <= ST_IDLE;
            div_q      <= '0;
            smp_q      <= '0;
            bit_q      <= '0;
            samp_q     <= '0;
            shift_q    <= '0;
            par_err_q  <= 1'b0;
            stop_low_q <= 1'b0;
            line_hi_q  <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            pe_q       <= 1'b0;
            fe_q       <= 1'b0;
            brk_q      <= 1'b0;
            ovr_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], uart_rxd_i};
            state_q    <= state_d;
            div_q      <= div_d;
            smp_q      <= smp_d;
            bit_q      <= bit_d;
            samp_q     <= samp_d;
            shift_q    <= shift_d;
            par_err_q  <= par_err_d;
            stop_low_q <= stop_low_d;
            line_hi_q  <= line_hi_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            pe_q       <= pe_d;
            fe_q       <= fe_d;
            brk_q      <= brk_d;
            ovr_q      <= ovr_d;
            busy_q     <= (state_d != ST_IDLE);
        end
    end

    assign rd_if.uart_rd_data  = data_q;
    assign rd_if.uart_rd_valid = valid_q;
    assign rd_if.rx_parity_err = pe_q;
    assign rd_if.rx_frame_err  = fe_q;
    assign rd_if.rx_break      = brk_q;
    assign rd_if.rx_overrun    = ovr_q;
    assign rx_busy_o           = busy_q;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: an 8N1 instance and a 7E1 instance, both run
// with DIV=4 and OVERSAMPLE=16 so one bit lasts 64 clocks.
module tb_uart_rx_cfg;
    localparam int CLK_FREQ = 7372800;
    localparam int BAUD     = 115200;
    localparam int T        = 64;

    logic clk = 1'b0;
    logic rst;
    logic rxd8, rxd7;
    logic busy8, busy7;

    int checks = 0;
    int errors = 0;
    int ovr_cnt = 0;

    logic [15:0] q8[$];
    logic [15:0] q7[$];

    always #5 clk = ~clk;

    uart_rx_cfg_if #(.DATA_BITS(8)) if8 ();
    uart_rx_cfg_if #(.DATA_BITS(7)) if7 ();

    uart_rx_cfg #(
        .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(16)
    ) u_dut8 (
        .clk(clk), .rst(rst), .uart_rxd_i(rxd8), .rx_busy_o(busy8), .rd_if(if8)
    );

    uart_rx_cfg #(
        .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(7),
        .PARITY(1), .STOP_BITS(1), .OVERSAMPLE(16)
    ) u_dut7 (
        .clk(clk), .rst(rst), .uart_rxd_i(rxd7), .rx_busy_o(busy7), .rd_if(if7)
    );

    // Record every completed transfer as {break, frame, parity, data}.
    always @(negedge clk) begin
        if (if8.uart_rd_valid && if8.uart_rd_ready)
            q8.push_back({5'd0, if8.rx_break, if8.rx_frame_err, if8.rx_parity_err, if8.uart_rd_data});
        if (if7.uart_rd_valid && if7.uart_rd_ready)
            q7.push_back({6'd0, if7.rx_break, if7.rx_frame_err, if7.rx_parity_err, if7.uart_rd_data});
        if (if8.rx_overrun) ovr_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pop8(input string tag, input logic [15:0] expv);
        logic [15:0] got;
        got = (q8.size() != 0) ? q8.pop_front() : 16'hFFFF;
        check(tag, {16'd0, got}, {16'd0, expv});
    endtask

    task automatic pop7(input string tag, input logic [15:0] expv);
        logic [15:0] got;
        got = (q7.size() != 0) ? q7.pop_front() : 16'hFFFF;
        check(tag, {16'd0, got}, {16'd0, expv});
    endtask

    task automatic send8(input logic [7:0] d, input logic stop_v);
        rxd8 = 1'b0;
        tick(T);
        for (int i = 0; i < 8; i++) begin
            rxd8 = d[i];
            tick(T);
        end
        rxd8 = stop_v;
        tick(T);
    endtask

    task automatic send7(input logic [6:0] d, input logic par_v);
        rxd7 = 1'b0;
        tick(T);
        for (int i = 0; i < 7; i++) begin
            rxd7 = d[i];
            tick(T);
        end
        rxd7 = par_v;
        tick(T);
        rxd7 = 1'b1;
        tick(T);
    endtask

    initial begin
        rst = 1'b1;
        rxd8 = 1'b1;
        rxd7 = 1'b1;
        if8.uart_rd_ready = 1'b1;
        if7.uart_rd_ready = 1'b1;
        tick(3);

        // Reset state
        check("rst_data", {24'd0, if8.uart_rd_data}, 32'h0);
        check("rst_valid", {31'd0, if8.uart_rd_valid}, 32'h0);
        check("rst_flags", {29'd0, if8.rx_break, if8.rx_frame_err, if8.rx_parity_err}, 32'h0);
        check("rst_overrun", {31'd0, if8.rx_overrun}, 32'h0);
        check("rst_busy", {31'd0, busy8}, 32'h0);
        rst = 1'b0;
        tick(T);

        // Four back-to-back 8N1 frames
        send8(8'h10, 1'b1);
        send8(8'h11, 1'b1);
        send8(8'h12, 1'b1);
        send8(8'h13, 1'b1);
        tick(2 * T);
        check("b2b_count", q8.size(), 32'd4);
        pop8("b2b_w0", 16'h010);
        pop8("b2b_w1", 16'h011);
        pop8("b2b_w2", 16'h012);
        pop8("b2b_w3", 16'h013);
        check("b2b_no_overrun", ovr_cnt, 32'd0);

        // 7E1: 0x55 has four ones, so the correct even parity bit is 0
        send7(7'h55, 1'b0);
        send7(7'h55, 1'b1);
        tick(T);
        check("par_count", q7.size(), 32'd2);
        pop7("par_ok", 16'h055);
        pop7("par_bad", 16'h0D5);

        // Short low glitch: busy latency, then rejection
        rxd8 = 1'b0;
        tick(2);
        check("busy_lat_2clk", {31'd0, busy8}, 32'h0);
        tick(1);
        check("busy_lat_3clk", {31'd0, busy8}, 32'h1);
        tick(17);
        rxd8 = 1'b1;
        tick(2 * T);
        check("glitch_busy", {31'd0, busy8}, 32'h0);
        check("glitch_no_word", q8.size(), 32'd0);
        send8(8'hA5, 1'b1);
        tick(T);
        pop8("after_glitch", 16'h0A5);

        // Framing error, then a 20-bit break
        send8(8'h3C, 1'b0);
        rxd8 = 1'b1;
        tick(T);
        pop8("frame_err_word", 16'h23C);
        rxd8 = 1'b0;
        tick(20 * T);
        check("break_count", q8.size(), 32'd1);
        check("break_busy_low", {31'd0, busy8}, 32'h1);
        pop8("break_word", 16'h600);
        rxd8 = 1'b1;
        tick(2 * T);
        check("break_no_more", q8.size(), 32'd0);
        send8(8'hA5, 1'b1);
        tick(T);
        pop8("after_break", 16'h0A5);

        // Overrun with the consumer stalled
        if8.uart_rd_ready = 1'b0;
        send8(8'h01, 1'b1);
        tick(T);
        check("stall_valid", {31'd0, if8.uart_rd_valid}, 32'h1);
        check("stall_data", {24'd0, if8.uart_rd_data}, 32'h01);
        send8(8'h02, 1'b1);
        tick(T);
        check("ovr_pulses", ovr_cnt, 32'd1);
        check("ovr_held_data", {24'd0, if8.uart_rd_data}, 32'h01);
        check("ovr_held_valid", {31'd0, if8.uart_rd_valid}, 32'h1);
        check("ovr_no_xfer", q8.size(), 32'd0);
        if8.uart_rd_ready = 1'b1;
        tick(1);
        check("xfer_valid_drop", {31'd0, if8.uart_rd_valid}, 32'h0);
        pop8("xfer_word", 16'h001);

        // Reset in the middle of data bit 3 of 0xFF
        rxd8 = 1'b0;
        tick(T);
        for (int i = 0; i < 3; i++) begin
            rxd8 = 1'b1;
            tick(T);
        end
        tick(T / 2);
        check("pre_rst_busy", {31'd0, busy8}, 32'h1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", {31'd0, busy8}, 32'h0);
        check("mid_rst_data", {24'd0, if8.uart_rd_data}, 32'h0);
        check("mid_rst_valid", {31'd0, if8.uart_rd_valid}, 32'h0);
        rxd8 = 1'b1;
        tick(5);
        rst = 1'b0;
        tick(T);
        send8(8'h3C, 1'b1);
        tick(T);
        check("post_rst_count", q8.size(), 32'd1);
        pop8("post_rst_word", 16'h03C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
